// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: op encodings, the
// op -> access size table, default exception codes and FSM encoding.
package mem_access_unit_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } mem_op_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } mau_state_e;

    localparam logic [4:0] ADEL_CODE_DEF = 5'd4;
    localparam logic [4:0] ADES_CODE_DEF = 5'd5;

    // Number of bytes touched by an op (as the memory's size encoding).
    function automatic logic [2:0] op_size(input mem_op_e op);
        case (op)
            OP_LW, OP_SW:          return 3'd4;
            OP_LH, OP_LHU, OP_SH:  return 3'd2;
            default:               return 3'd1;
        endcase
    endfunction

    function automatic logic op_is_store(input mem_op_e op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extender.sv
// Sign/zero extension of raw memory read data for the load ops.
// Ports:
//   op          in  3   request op (mem_op_e encoding)
//   dm_data_out in  32  memory read data, addressed byte in [7:0]
//   result      out 32  extended load value (raw data for non-load ops)
module load_extender
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] dm_data_out,
    output logic [31:0] result
);

    always_comb begin
        result = dm_data_out;
        case (mem_op_e'(op))
            OP_LH:   result = {{16{dm_data_out[15]}}, dm_data_out[15:0]};
            OP_LHU:  result = {16'h0000, dm_data_out[15:0]};
            OP_LB:   result = {{24{dm_data_out[7]}}, dm_data_out[7:0]};
            OP_LBU:  result = {24'h000000, dm_data_out[7:0]};
            default: result = dm_data_out;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage front end in front of the data memory. Takes one
// load/store/pass-through request per cycle, drives the memory's sized
// read/write ports combinationally, extends load data and registers the
// result (or an address-error exception) for write-back. After an
// exception the unit halts until flushed.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   req_*                   request channel (valid/ready)
//   flush                   drop the output register, leave HALTED
//   dm_*                    data memory interface
//   wb_*                    registered write-back result (valid/ready)
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter logic [4:0] ADEL_CODE = ADEL_CODE_DEF,
    parameter logic [4:0] ADES_CODE = ADES_CODE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_mem,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_address,
    input  logic [31:0] req_data,
    input  logic [4:0]  req_rd,
    input  logic [31:0] req_pc,
    input  logic        flush,
    output logic [31:0] dm_address,
    output logic [31:0] dm_data_in,
    output logic [2:0]  dm_read_size,
    output logic [2:0]  dm_write_size,
    input  logic        dm_accepted,
    input  logic [31:0] dm_data_out,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_pc,
    output logic        wb_exception,
    output logic [4:0]  wb_exc_code
);

    mau_state_e  state_q, state_d;
    logic        fire;
    logic        is_store;
    logic        mem_fault;
    logic [2:0]  size;
    logic [31:0] load_result;

    assign is_store   = op_is_store(mem_op_e'(req_op));
    assign size       = op_size(mem_op_e'(req_op));
    assign dm_address = req_address;
    assign dm_data_in = req_data;
    // dm_accepted only means something while we actually drive a size,
    // which happens only on a firing memory op.
    assign mem_fault  = req_is_mem & ~dm_accepted;

    load_extender u_load_extender (
        .op          (req_op),
        .dm_data_out (dm_data_out),
        .result      (load_result)
    );

    // Next state, handshake and memory drive.
    always_comb begin
        state_d       = state_q;
        req_ready     = (state_q == ST_RUN) & (~wb_valid | wb_ready) & ~flush;
        fire          = req_valid & req_ready;
        dm_read_size  = 3'd0;
        dm_write_size = 3'd0;
        if (fire && req_is_mem) begin
            if (is_store) dm_write_size = size;
            else          dm_read_size  = size;
        end
        if (flush)                  state_d = ST_RUN;
        else if (fire && mem_fault) state_d = ST_HALTED;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_rd        <= '0;
            wb_pc        <= '0;
            wb_exception <= 1'b0;
            wb_exc_code  <= '0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                wb_valid     <= 1'b0;
                wb_exception <= 1'b0;
            end else if (fire) begin
                // A fire replaces the output register even if it is being
                // consumed in the same cycle, so there is no bubble.
                wb_valid <= 1'b1;
                wb_rd    <= req_rd;
                wb_pc    <= req_pc;
                if (mem_fault) begin
                    wb_exception <= 1'b1;
                    wb_data      <= req_address;
                    wb_exc_code  <= is_store ? ADES_CODE : ADEL_CODE;
                end else begin
                    wb_exception <= 1'b0;
                    wb_exc_code  <= '0;
                    if (!req_is_mem)   wb_data <= req_data;
                    else if (is_store) wb_data <= '0;
                    else               wb_data <= load_result;
                end
            end else if (wb_valid && wb_ready) begin
                wb_valid <= 1'b0;
            end
        end
    end

endmodule
